dst_stream_out: RTL and testbench
=================================

# dst_stream_out

Read-out stage that sits directly downstream of `dst_buf`. On a `start` pulse it reads a contiguous run of result pairs from one `dst_buf` bank through the `dst_v`/`dst_a`/`dst_d0`/`dst_d1` port. It emits them as a valid/ready stream with `m_last` on the final pair. It absorbs the buffer's one-cycle read latency and downstream backpressure with a 4-entry output FIFO and credit-based read issue.

## Interface
- `FIFO_DEPTH`, 4, output FIFO entries (≥3 for full throughput; fixed 4 in this release)
- `clk`  in  1  clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `start`  in  1  one-cycle request; sampled only in IDLE
- `base`  in  13  start address: bit 12 = bank, bits [10:0] = first pair index, bit 11 ignored
- `words`  in  12  pairs to transfer, 0..2048; sampled with `start`
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse at end of transfer
- `dst_v`  out  1  read strobe to `dst_buf` (registered)
- `dst_a`  out  13  read address to `dst_buf` (registered)
- `dst_d0`, `dst_d1`  in  real  pair read data, valid the cycle after the `dst_v` edge
- `m_valid`  out  1  stream data valid
- `m_ready`  in  1  stream accept
- `m_data0`, `m_data1`  out  real  stream pair (`m_data0` = even element)
- `m_last`  out  1  high with the final pair of the transfer

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `base`, `words`; `issued`=0.
  - `words`=0 → DONE; else → RUN.
- RUN: read issue and pair capture.
  - Issue condition: `issued < words` and `count + pending - pop < 4`.
    - `count` = FIFO occupancy.
    - `pending` = reads issued but not yet captured (0..2).
    - `pop` = `m_valid & m_ready`.
  - Issuing registers `dst_v`=1 and `dst_a` = {bank, 1'b0, idx}, then increments `issued` and `idx`.
  - `idx` wraps 2047→0 inside the bank. The bank bit never changes within a transfer.
  - The cycle after a `dst_v` cycle, `dst_d0`/`dst_d1` are pushed into the FIFO. `m_last` = (pushed ordinal == `words`).
  - `issued == words` → DRAIN.
- DRAIN: no new reads. When `count`=0 and `pending`=0 → DONE.
- DONE: `done`=1 for one cycle → IDLE. `busy` falls with the same edge.
- `dst_a` holds its last value after the final read. `dst_buf` muxes read data by `dst_a[12]`, so the bank bit must stay stable through capture.
- `start` while not IDLE is ignored.
- Exclusivity: compute-side `outr`/`accr` traffic has priority inside `dst_buf`. The integrating controller guarantees no such traffic to the selected bank while `busy`. The block does not detect a lost read.
- Reset, including mid-transfer:
  - State → IDLE; FIFO, `pending`, `issued` cleared.
  - `busy`, `done`, `dst_v`, `m_valid`, `m_last` = 0; `dst_a` = 0.
  - `m_data0`/`m_data1` = 0.0.
  - In-flight read data is discarded.

## Timing
- Edge E0 samples `start`.
- E1: `dst_v`=1 with the first address.
- E2: `dst_buf` output valid; E2 capture.
- `m_valid`=1 after E2, i.e. start→first `m_valid` is 2 cycles.
- `m_ready` held high: one pair per cycle, no bubbles. The last beat leaves N+1 cycles after E0. `done` follows 1 cycle after the last pop.
- `m_ready` low: at most 4 pairs buffered. `dst_v` deasserts once `count + pending` reaches 4. Reads resume the cycle after a pop frees credit.
- `m_data*`/`m_last` are stable while `m_valid & ~m_ready`. `m_valid` never drops without a pop.
- Simultaneous push and pop with a full FIFO is legal; `count` stays unchanged.
- `words`=2048 starting at idx 0 reads every pair of the bank exactly once.

## Test plan
- bank0 filled with `buff0[k]`=k. `base`=0, `words`=4, `m_ready`=1 → stream (0,1),(2,3),(4,5),(6,7) on consecutive cycles starting 2 cycles after `start`; `m_last` on (6,7); `done` 1 cycle after.
- `base`=13'h1000|2046, `words`=3 on bank1 → `dst_a` 0x17FE, 0x17FF, 0x1000; pairs from indices 4092..4095 then 0..1; bank bit constant.
- `words`=8, `m_ready`=0 for 20 cycles, then 1 → exactly 4 `dst_v` pulses before stall; no data loss or duplication; 8 beats in order.
- `m_ready` toggling 1,0,1,0… with `words`=16 → 16 beats in order, held data stable while stalled, `m_last` only on beat 16.
- `words`=0 → no `dst_v`, no `m_valid`; `done` pulses 1 cycle after `start`. `start` during `busy` → ignored.
- `rst_n` low mid-transfer (after 3 beats of 10) → all outputs 0 asynchronously. A new `start` with `words`=2 then completes cleanly.

Source files
------------

// File: rtl/dst_stream_out_if.sv
// dst_stream_out_if: valid/ready pair stream carrying dst_buf read-out data
interface dst_stream_out_if;
  logic m_valid, m_ready, m_last;
  real m_data0, m_data1;
  modport master(output m_valid, m_data0, m_data1, m_last, input m_ready);
  modport slave(input m_valid, m_data0, m_data1, m_last, output m_ready);
endinterface

// File: rtl/dst_stream_out.sv
// dst_stream_out: reads a run of pairs from one dst_buf bank and streams them out through a credit-throttled FIFO
module dst_stream_out #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [12:0] base,
  input  logic [11:0] words,
  output logic        busy,
  output logic        done,
  output logic        dst_v,
  output logic [12:0] dst_a,
  input  real         dst_d0,
  input  real         dst_d1,
  dst_stream_out_if.master m
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic bank;
  logic [10:0] idx;
  logic [11:0] words_q, issued, pushed;
  logic [AW:0] count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  real mem0 [FIFO_DEPTH];
  real mem1 [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_q;
  logic pop, issue, unused;
  logic [AW+1:0] credit, limit;
  assign unused = base[11];
  assign pop = m.m_valid & m.m_ready;
  // a read in flight (dst_v high) already owns a FIFO slot
  assign credit = (AW+2)'(count) + (AW+2)'(dst_v);
  assign limit = (AW+2)'(FIFO_DEPTH) + (AW+2)'(pop);
  assign issue = state == RUN && issued < words_q && credit < limit;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign m.m_valid = count != '0;
  assign m.m_data0 = mem0[rd_ptr];
  assign m.m_data1 = mem1[rd_ptr];
  assign m.m_last = m.m_valid & last_q[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = words == '0 ? DONE : RUN;
      RUN:   if (issued == words_q) state_nxt = DRAIN;
      DRAIN: if (!dst_v && (count == '0 || (count == (AW+1)'(1) && pop))) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
      bank <= 1'b0;
      idx <= '0;
      issued <= '0;
      pushed <= '0;
      dst_v <= 1'b0;
      dst_a <= '0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem0[i] <= 0.0;
        mem1[i] <= 0.0;
      end
    end else begin
      dst_v <= issue;
      if (issue) begin
        dst_a <= {bank, 1'b0, idx};
        idx <= idx + 11'd1;
        issued <= issued + 12'd1;
      end
      if (state == IDLE && start) begin
        words_q <= words;
        bank <= base[12];
        idx <= base[10:0];
        issued <= '0;
        pushed <= '0;
      end
      // read data is valid the cycle after the strobe
      if (dst_v) begin
        mem0[wr_ptr] <= dst_d0;
        mem1[wr_ptr] <= dst_d1;
        last_q[wr_ptr] <= pushed + 12'd1 == words_q;
        pushed <= pushed + 12'd1;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(dst_v) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_dst_stream_out.sv
// tb_dst_stream_out: table-driven transfers against a behavioural dst_buf, plus reset-mid-transfer sequence
module tb_dst_stream_out;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [12:0] base = '0;
  logic [11:0] words = '0;
  logic busy, done, dst_v;
  logic [12:0] dst_a;
  real dst_d0, dst_d1;
  int checks = 0, errors = 0;
  typedef struct {
    logic [12:0] base;
    logic [11:0] words;
    int mode;
    int exp_first;
    int exp_done;
    int ign;
  } vec_t;
  vec_t vecs[7];
  dst_stream_out_if m();
  dst_stream_out dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .words(words),
    .busy(busy), .done(done), .dst_v(dst_v), .dst_a(dst_a),
    .dst_d0(dst_d0), .dst_d1(dst_d1), .m(m)
  );
  always #5 clk = ~clk;
  function automatic real val(input logic [12:0] a, input bit odd);
    return (a[12] ? 10000.0 : 0.0) + 2.0 * a[10:0] + (odd ? 1.0 : 0.0);
  endfunction
  function automatic logic [12:0] addr(input vec_t v, input int k);
    logic [10:0] i;
    i = v.base[10:0] + 11'(k);
    return {v.base[12], 1'b0, i};
  endfunction
  // combinational model of the dst_buf read port: data follows the registered strobe/address
  assign dst_d0 = dst_v ? val(dst_a, 1'b0) : -1.0;
  assign dst_d1 = dst_v ? val(dst_a, 1'b1) : -1.0;
  task automatic chk(input string n, input real act, input real exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0.1f expected %0.1f", n, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    int ni = 0, nb = 0, lp = -1, nv = 0, w;
    bit pv = 0, pr = 0, got = 0, first = 0;
    real p0 = 0.0, p1 = 0.0;
    logic pl = 1'b0;
    logic [12:0] ea;
    w = int'(v.words);
    @(negedge clk);
    base = v.base;
    words = v.words;
    start = 1'b1;
    m.m_ready = 1'b0;
    for (int c = 0; c < 2 * w + 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == v.ign) begin
        start = 1'b1;
        base = 13'h0123;
        words = 12'd5;
      end
      m.m_ready = v.mode == 0 ? 1'b1 : v.mode == 1 ? (c % 2 == 0) : (c >= 20);
      if (c == 0) chk("busy_after_start", busy, 1);
      if (dst_v) begin
        ea = addr(v, ni);
        chk("dst_a", dst_a, ea);
        ni++;
        if (c < 20) nv++;
      end
      if (v.mode == 2 && c == 19) chk("reads_before_stall", nv, 4);
      if (pv && !pr) begin
        chk("valid_held", m.m_valid, 1);
        chk("held_d0", m.m_data0, p0);
        chk("held_d1", m.m_data1, p1);
        chk("held_last", m.m_last, pl);
      end
      if (m.m_valid) begin
        if (!first && v.exp_first >= 0) chk("first_valid_cycle", c, v.exp_first);
        first = 1;
        if (m.m_ready) begin
          ea = addr(v, nb);
          chk("beat_d0", m.m_data0, val(ea, 1'b0));
          chk("beat_d1", m.m_data1, val(ea, 1'b1));
          chk("beat_last", m.m_last, nb == w - 1);
          nb++;
          lp = c;
        end
      end
      pv = m.m_valid;
      pr = m.m_ready;
      p0 = m.m_data0;
      p1 = m.m_data1;
      pl = m.m_last;
      if (done) begin
        if (v.exp_done >= 0) chk("done_cycle", c, v.exp_done);
        if (w != 0) chk("done_after_last_pop", c, lp + 1);
        chk("beats", nb, w);
        chk("reads", ni, w);
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, expected done within %0d cycles", 2 * w + 60);
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", busy, 0);
    chk("dst_v_idle", dst_v, 0);
    chk("valid_idle", m.m_valid, 0);
    chk("done_one_cycle", done, 0);
  endtask
  initial begin
    vecs[0] = '{13'h0000, 12'd4, 0, 2, 6, 3};
    vecs[1] = '{13'h17FE, 12'd3, 0, 2, 5, -1};
    vecs[2] = '{13'h0000, 12'd8, 2, 2, -1, -1};
    vecs[3] = '{13'h0010, 12'd16, 1, 2, -1, 5};
    vecs[4] = '{13'h0000, 12'd0, 0, -1, 0, 0};
    vecs[5] = '{13'h1005, 12'd1, 0, 2, 3, -1};
    vecs[6] = '{13'h0000, 12'd2048, 0, 2, 2050, -1};
    m.m_ready = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dst_v", dst_v, 0);
    chk("rst_dst_a", dst_a, 0);
    chk("rst_valid", m.m_valid, 0);
    chk("rst_last", m.m_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) run(vecs[i]);
    @(negedge clk);
    base = 13'h0000;
    words = 12'd10;
    start = 1'b1;
    m.m_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("mid_busy", busy, 1);
    chk("mid_valid", m.m_valid, 1);
    chk("mid_d0", m.m_data0, 6.0);
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_dst_v", dst_v, 0);
    chk("async_dst_a", dst_a, 0);
    chk("async_valid", m.m_valid, 0);
    chk("async_last", m.m_last, 0);
    chk("async_d0", m.m_data0, 0.0);
    chk("async_d1", m.m_data1, 0.0);
    @(negedge clk);
    rst_n = 1'b1;
    run('{13'h0020, 12'd2, 0, 2, 4, -1});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
